usrt_frame_cntr: RTL and testbench
==================================

Name: usrt_frame_cntr

Overview:
- Parametrised USRT frame bit counter; successor to the fixed-length bit counter in the transmit path.
- Tracks the bit position within one serial frame (start, data, optional parity, 1 or 2 stop bits) at the bit-rate enable.
- Signals frame completion to the shift register and to the control FSM.
- Adds over the previous generation: runtime data length, stop-bit count, edge-qualified bit enable, RTS pause, abort, back-to-back frames and a phase output.

Parameters:
- DATA_MAX, 16: maximum data bits per frame; legal range 1..32.
- EN_EDGE, 1: 1 = advance on rising edge of en_usrt; 0 = advance on every clk with en_usrt high.
- CW, $clog2(DATA_MAX+5): width of cout; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- START  in  1  frame request; sampled in IDLE, and at frame end for back-to-back frames.
- abort  in  1  synchronous abort; returns to IDLE without max.
- data_len  in  $clog2(DATA_MAX+1)  number of data bits; latched at frame start.
- par_en  in  1  parity bit present; latched at frame start.
- stop2  in  1  0 = one stop bit, 1 = two; latched at frame start.
- en_usrt  in  1  bit-rate enable from the baud generator.
- RTS  in  1  1 = allowed to send; 0 = counting paused.
- cout  out  CW  index of the current bit; 0 = start bit.
- phase  out  3  0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
- busy  out  1  high from frame start until frame end.
- max  out  1  one-clk pulse on the advance out of the last bit of the frame.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, cout=0, phase=0, busy=0, max=0, edge register=0, latched config=0. Reset has priority over every other input, including in mid-frame.
- adv = (EN_EDGE ? en_usrt & ~en_q : en_usrt) & RTS & busy. en_q is en_usrt registered every clk, regardless of RTS.
  - An en_usrt edge that occurs while RTS=0 is lost; it is not queued.
- Frame length L = 1 + dl + par_en + (stop2 ? 2 : 1), where dl is data_len clamped as follows:
  - 0 is treated as 1.
  - Values above DATA_MAX are treated as DATA_MAX.
- IDLE: START=1 at a clk edge → latch dl, par_en and stop2; state START; cout=0; busy=1 on the next cycle. No adv is required to start.
- START, on adv → DATA, cout=1.
- DATA, on adv:
  - Increment cout.
  - After dl data bits, go to PARITY if par_en, else STOP.
- PARITY, on adv → STOP, cout+1.
- STOP, on adv:
  - If cout < L-1: increment cout.
  - If cout = L-1: max=1 for one clk.
    - If START=1 in that same cycle: relatch config, go to START, cout=0, busy stays 1.
    - Otherwise: go to IDLE, cout=0, busy=0.
- Latency: max is registered and asserts in the clk after the qualifying adv edge. cout and phase update in the same clk as max.
- START while busy (other than in the final adv cycle) is ignored. Input changes mid-frame are ignored.
- abort=1 → IDLE, cout=0, busy=0, max=0 on the next clk. Priority order: rst > abort > adv > START.
- RTS=0 freezes cout, phase and busy. No max is generated while RTS=0.
- cout never exceeds L-1; no wrap-around inside a frame.

Decomposition:
- Shared package usrt_pkg holds:
  - phase encodings PH_IDLE..PH_STOP as a 3-bit typedef usrt_phase_t;
  - the frame-length function;
  - the DATA_MAX default.
- One natural sub-module: usrt_en_edge, the en_usrt registering and rising-edge/level qualification selected by EN_EDGE. The FSM and counter stay in this module.

Test Plan:
- Basic frame: rst low 1 clk; data_len=8, par_en=0, stop2=0; START pulse; en_usrt toggling every 2 clks → L=10, cout runs 0..9, exactly one max pulse after the 10th en edge, then busy=0 and cout=0.
- Parity plus two stop bits: data_len=8, par_en=1, stop2=1 → L=12; phase sequence 1,2×8,3,4,4; max after the 12th edge.
- RTS pause: RTS=0 for 3 en edges during DATA at cout=4 → cout holds 4; edges are lost; frame completes 3 edges later than in the basic frame case; max count = 1.
- Clamping: data_len=0 → L=3 (cout 0,1,2); data_len=31 with DATA_MAX=16 → L=18.
- Back-to-back and ignored START: START held high through the last adv → immediate new frame with cout=0 and busy never drops. START pulse at cout=5 mid-frame → no effect on cout.
- Reset and abort mid-frame: rst=0 at cout=6 → next clk all outputs 0, no max. abort at cout=3 → IDLE, busy=0, no max; a subsequent START begins a clean frame.

Source files
------------

// File: rtl/usrt_pkg.sv
// +--------------------------------------------------------------------+
// | usrt_pkg : shared phase encodings and frame-length helper (rev 1.0) |
// +--------------------------------------------------------------------+
`default_nettype none

package usrt_pkg;

    localparam int unsigned USRT_DATA_MAX_DEF = 16;

    typedef logic [2:0] usrt_phase_t;

    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_START  = 3'd1;
    localparam logic [2:0] PH_DATA   = 3'd2;
    localparam logic [2:0] PH_PARITY = 3'd3;
    localparam logic [2:0] PH_STOP   = 3'd4;

    // Total bits in a frame; dl must already be clamped to 1..DATA_MAX.
    function automatic logic [7:0] usrt_frame_len(
        input logic [7:0] dl,
        input logic       par,
        input logic       two_stop
    );
        return 8'd1 + dl + {7'd0, par} + (two_stop ? 8'd2 : 8'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/usrt_en_edge.sv
// +--------------------------------------------------------------------+
// | usrt_en_edge : bit-rate enable edge/level qualifier       (rev 1.0) |
// +--------------------------------------------------------------------+
`default_nettype none

module usrt_en_edge #(
    parameter int EN_EDGE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_usrt_i,
    output logic en_qual_o
);

    logic en_q;

    // Tracks en_usrt unconditionally, so an edge seen while paused is consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_usrt_i;
        end
    end

    assign en_qual_o = (EN_EDGE != 0) ? (en_usrt_i & ~en_q) : en_usrt_i;

endmodule

`default_nettype wire

// File: rtl/usrt_frame_cntr.sv
// +--------------------------------------------------------------------+
// | usrt_frame_cntr : USRT frame bit counter with phase output (rev 1.0)|
// +--------------------------------------------------------------------+
`default_nettype none

module usrt_frame_cntr
    import usrt_pkg::*;
#(
    parameter int DATA_MAX = USRT_DATA_MAX_DEF,
    parameter int EN_EDGE  = 1,
    parameter int CW       = $clog2(DATA_MAX + 5)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            START,
    input  logic                            abort,
    input  logic [$clog2(DATA_MAX+1)-1:0]   data_len,
    input  logic                            par_en,
    input  logic                            stop2,
    input  logic                            en_usrt,
    input  logic                            RTS,
    output logic [CW-1:0]                   cout,
    output logic [2:0]                      phase,
    output logic                            busy,
    output logic                            max
);

    localparam int DLW = $clog2(DATA_MAX + 1);

    usrt_phase_t   state_q, state_d;
    logic [CW-1:0] cout_q,  cout_d;
    logic [CW-1:0] dl_q,    dl_d;
    logic [CW-1:0] last_q,  last_d;
    logic          par_q,   par_d;
    logic          busy_q,  busy_d;
    logic          max_q,   max_d;

    logic          en_qual;
    logic          adv;
    logic          load;
    logic [DLW-1:0] dl_clamped;

    usrt_en_edge #(
        .EN_EDGE (EN_EDGE)
    ) u_en_edge (
        .clk       (clk),
        .rst       (rst),
        .en_usrt_i (en_usrt),
        .en_qual_o (en_qual)
    );

    assign adv = en_qual & RTS & busy_q;

    always_comb begin
        dl_clamped = data_len;
        if (data_len == '0) begin
            dl_clamped = DLW'(1);
        end else if (int'(data_len) > DATA_MAX) begin
            dl_clamped = DLW'(DATA_MAX);
        end
    end

    always_comb begin
        state_d = state_q;
        cout_d  = cout_q;
        dl_d    = dl_q;
        last_d  = last_q;
        par_d   = par_q;
        busy_d  = busy_q;
        max_d   = 1'b0;
        load    = 1'b0;

        if (abort) begin
            state_d = PH_IDLE;
            cout_d  = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                PH_IDLE: begin
                    load = START;
                end
                PH_START: begin
                    if (adv) begin
                        state_d = PH_DATA;
                        cout_d  = CW'(1);
                    end
                end
                PH_DATA: begin
                    if (adv) begin
                        cout_d = cout_q + CW'(1);
                        // Data bits occupy indices 1..dl.
                        if (cout_q == dl_q) begin
                            state_d = par_q ? PH_PARITY : PH_STOP;
                        end
                    end
                end
                PH_PARITY: begin
                    if (adv) begin
                        state_d = PH_STOP;
                        cout_d  = cout_q + CW'(1);
                    end
                end
                PH_STOP: begin
                    if (adv) begin
                        if (cout_q < last_q) begin
                            cout_d = cout_q + CW'(1);
                        end else begin
                            max_d = 1'b1;
                            if (START) begin
                                load = 1'b1;
                            end else begin
                                state_d = PH_IDLE;
                                cout_d  = '0;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = PH_IDLE;
                    cout_d  = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end

        if (load) begin
            state_d = PH_START;
            cout_d  = '0;
            busy_d  = 1'b1;
            dl_d    = CW'(dl_clamped);
            par_d   = par_en;
            last_d  = CW'(usrt_frame_len(8'(dl_clamped), par_en, stop2) - 8'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PH_IDLE;
            cout_q  <= '0;
            dl_q    <= '0;
            last_q  <= '0;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
            max_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cout_q  <= cout_d;
            dl_q    <= dl_d;
            last_q  <= last_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
            max_q   <= max_d;
        end
    end

    assign cout  = cout_q;
    assign phase = state_q;
    assign busy  = busy_q;
    assign max   = max_q;

endmodule

`default_nettype wire

// File: tb/tb_usrt_frame_cntr.sv
// +--------------------------------------------------------------------+
// | tb_usrt_frame_cntr : scoreboard bench with frame-level model (rev 1.0)|
// +--------------------------------------------------------------------+
`default_nettype none

module tb_usrt_frame_cntr;

    localparam int DATA_MAX = 16;
    localparam int CW       = $clog2(DATA_MAX + 5);
    localparam int DLW      = $clog2(DATA_MAX + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, start, abort, par_en, stop2, en_usrt, rts;
    logic [DLW-1:0] data_len;
    logic [CW-1:0]  cout;
    logic [2:0]     phase;
    logic           busy, max;

    usrt_frame_cntr #(
        .DATA_MAX (DATA_MAX),
        .EN_EDGE  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .START    (start),
        .abort    (abort),
        .data_len (data_len),
        .par_en   (par_en),
        .stop2    (stop2),
        .en_usrt  (en_usrt),
        .RTS      (rts),
        .cout     (cout),
        .phase    (phase),
        .busy     (busy),
        .max      (max)
    );

    typedef struct packed {
        logic [CW-1:0] cout;
        logic [2:0]    phase;
        logic          busy;
        logic          max;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   dut_max_cnt = 0;
    int   m_max_cnt   = 0;

    // Frame-level model: a bit index within a frame of known length.
    bit m_busy, m_max, m_enprev, m_par;
    int m_idx, m_len, m_dl;
    int en_cnt = 0;
    bit auto_en = 1'b1;

    function automatic int clamp_dl(int raw);
        if (raw == 0) return 1;
        if (raw > DATA_MAX) return DATA_MAX;
        return raw;
    endfunction

    function automatic logic [2:0] phase_of(int idx, int dl, bit par);
        if (idx == 0) return 3'd1;
        if (idx <= dl) return 3'd2;
        if (par && idx == dl + 1) return 3'd3;
        return 3'd4;
    endfunction

    task automatic model_load();
        m_dl   = clamp_dl(int'(data_len));
        m_par  = par_en;
        m_len  = 1 + m_dl + (par_en ? 1 : 0) + (stop2 ? 2 : 1);
        m_idx  = 0;
        m_busy = 1'b1;
    endtask

    task automatic model_update();
        bit edge_seen, step_bit;
        m_max = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_idx = 0; m_enprev = 1'b0;
            m_dl = 0; m_par = 1'b0; m_len = 0;
        end else begin
            edge_seen = en_usrt && !m_enprev;
            m_enprev  = en_usrt;
            step_bit  = edge_seen && rts && m_busy;
            if (abort) begin
                m_busy = 1'b0; m_idx = 0;
            end else if (step_bit) begin
                if (m_idx < m_len - 1) begin
                    m_idx++;
                end else begin
                    m_max = 1'b1;
                    if (start) model_load();
                    else begin m_busy = 1'b0; m_idx = 0; end
                end
            end else if (!m_busy && start) begin
                model_load();
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.cout  = CW'(m_idx);
        e.phase = m_busy ? phase_of(m_idx, m_dl, m_par) : 3'd0;
        e.busy  = m_busy;
        e.max   = m_max;
        return e;
    endfunction

    task automatic step();
        if (auto_en) begin
            en_usrt = en_cnt[1];
            en_cnt++;
        end
        model_update();
        @(posedge clk);
        #1;
        exp_q.push_back(model_out());
        if (m_max) m_max_cnt++;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string nm, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic pulse_start(int len, bit par, bit s2);
        data_len = DLW'(len);
        par_en   = par;
        stop2    = s2;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_idx(string nm, int n);
        int k;
        for (k = 0; k < 400 && !(m_busy && m_idx == n); k++) step();
        if (!(m_busy && m_idx == n)) chk({nm, "_reach_idx"}, k, -1);
    endtask

    // Monitor: pops the expected response for every presented output cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (cout !== e.cout || phase !== e.phase || busy !== e.busy || max !== e.max) begin
                n_errs++;
                $display("FAIL outputs @%0t: got cout=%0d phase=%0d busy=%0b max=%0b, expected cout=%0d phase=%0d busy=%0b max=%0b",
                         $time, cout, phase, busy, max, e.cout, e.phase, e.busy, e.max);
            end
            if (max === 1'b1) dut_max_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mc0, dc0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; par_en = 1'b0; stop2 = 1'b0;
        en_usrt = 1'b0; rts = 1'b1; data_len = '0;

        step();
        drain();
        chk("reset_cout", int'(cout), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_phase", int'(phase), 0);
        rst_n = 1'b1;
        run(3);

        // Basic 8N1 frame
        dc0 = dut_max_cnt; mc0 = m_max_cnt;
        pulse_start(8, 1'b0, 1'b0);
        wait_idx("basic", 9);
        drain();
        chk("basic_cout_last", int'(cout), 9);
        chk("basic_phase_last", int'(phase), 4);
        run(10);
        drain();
        chk("basic_max_count", dut_max_cnt - dc0, 1);
        chk("basic_idle_busy", int'(busy), 0);

        // 8 data, parity, two stop bits
        dc0 = dut_max_cnt;
        pulse_start(8, 1'b1, 1'b1);
        wait_idx("par2", 9);
        drain();
        chk("par2_phase_parity", int'(phase), 3);
        run(20);
        drain();
        chk("par2_max_count", dut_max_cnt - dc0, 1);

        // RTS pause at cout=4
        dc0 = dut_max_cnt;
        pulse_start(8, 1'b0, 1'b0);
        wait_idx("rts", 4);
        rts = 1'b0;
        run(12);
        drain();
        chk("rts_hold_cout", int'(cout), 4);
        rts = 1'b1;
        run(40);
        drain();
        chk("rts_max_count", dut_max_cnt - dc0, 1);

        // Clamping: 0 -> 1 data bit, 31 -> DATA_MAX
        dc0 = dut_max_cnt;
        pulse_start(0, 1'b0, 1'b0);
        wait_idx("clamp0", 2);
        drain();
        chk("clamp0_phase", int'(phase), 4);
        run(8);
        pulse_start(31, 1'b0, 1'b0);
        wait_idx("clamp31", 17);
        drain();
        chk("clamp31_cout_last", int'(cout), 17);
        run(10);
        drain();
        chk("clamp_max_count", dut_max_cnt - dc0, 2);

        // Back-to-back frames with START held, then ignored mid-frame START
        dc0 = dut_max_cnt;
        data_len = DLW'(3); par_en = 1'b0; stop2 = 1'b0; start = 1'b1;
        run(30);
        start = 1'b0;
        run(30);
        drain();
        chk("b2b_max_count", dut_max_cnt - dc0, 2);
        pulse_start(8, 1'b0, 1'b0);
        wait_idx("midstart", 5);
        start = 1'b1; data_len = DLW'(2);
        step();
        start = 1'b0;
        run(45);

        // Reset mid-frame
        dc0 = dut_max_cnt;
        pulse_start(8, 1'b0, 1'b0);
        wait_idx("rstmid", 6);
        rst_n = 1'b0;
        step();
        drain();
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_cout", int'(cout), 0);
        rst_n = 1'b1;
        run(6);

        // Abort mid-frame, then a clean frame
        pulse_start(8, 1'b0, 1'b0);
        wait_idx("abort", 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        drain();
        chk("abort_busy", int'(busy), 0);
        chk("abort_no_max", dut_max_cnt - dc0, 0);
        pulse_start(5, 1'b1, 1'b0);
        run(40);
        drain();
        chk("after_abort_max", dut_max_cnt - dc0, 1);

        // Randomised traffic
        auto_en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            en_usrt  = ($urandom_range(0, 2) == 0);
            rts      = ($urandom_range(0, 9) != 0);
            start    = ($urandom_range(0, 7) == 0);
            abort    = ($urandom_range(0, 99) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            data_len = DLW'($urandom_range(0, (1 << DLW) - 1));
            par_en   = $urandom_range(0, 1) == 1;
            stop2    = $urandom_range(0, 1) == 1;
            step();
        end
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        drain();
        chk("random_max_count", dut_max_cnt, m_max_cnt);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) drain();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
